// File: rtl/fb_draw_writer.sv
// Frame-buffer write engine: pixel, rectangle-fill and full-clear commands for a
// 640x480 8-bit colour-index frame buffer, one write per cycle at row*H_RES + col.
// Optional build macro FB_VBLANK_GATE_EN adds a vblank input; writes then stall
// (address and counters hold) on cycles with vblank low.
module fb_draw_writer #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
`ifdef FB_VBLANK_GATE_EN
  input  logic              vblank,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [8:0]        cmd_row,
  input  logic [9:0]        cmd_col,
  input  logic [8:0]        cmd_h,
  input  logic [9:0]        cmd_w,
  input  logic [IDX_W-1:0]  cmd_color,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [IDX_W-1:0]  wr_data,
  output logic              done,
  output logic              err
);

  localparam logic [9:0]        HLast   = 10'(H_RES - 1);
  localparam logic [8:0]        VLast   = 9'(V_RES - 1);
  localparam logic [ADDR_W-1:0] HStride = ADDR_W'(H_RES);

  typedef enum logic [2:0] {StIdle, StPix, StRect, StClr, StFin} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] wr_addr_q, row_start_q;
  logic [IDX_W-1:0]  color_q;
  logic [9:0]        col_q, col_start_q, end_col_q;
  logic [8:0]        row_q, end_row_q;
  logic              done_q, err_q;

  logic              accept, drawing, gate, fire;
  logic [10:0]       col_sum;
  logic [9:0]        row_sum;
  logic [9:0]        end_col_c;
  logic [8:0]        end_row_c;
  logic              row_oob, col_oob;
  logic [ADDR_W-1:0] start_addr;

  // FIN counts as ready so a new command can be taken while done pulses.
  assign cmd_ready = (state_q == StIdle) || (state_q == StFin);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign drawing   = (state_q == StPix) || (state_q == StRect) || (state_q == StClr);

`ifdef FB_VBLANK_GATE_EN
  assign gate = vblank;
`else
  assign gate = 1'b1;
`endif

  // A write happens on every drawing cycle that is not stalled.
  assign fire    = drawing & gate;
  assign wr_en   = fire;
  assign wr_addr = wr_addr_q;
  assign wr_data = color_q;
  assign done    = done_q;
  assign err     = err_q;

  // Command decode: range checks, silent clipping and the one multiply for the start address.
  assign col_sum    = {1'b0, cmd_col} + {1'b0, cmd_w} - 11'd1;
  assign row_sum    = {1'b0, cmd_row} + {1'b0, cmd_h} - 10'd1;
  assign end_col_c  = (col_sum > {1'b0, HLast}) ? HLast : col_sum[9:0];
  assign end_row_c  = (row_sum > {1'b0, VLast}) ? VLast : row_sum[8:0];
  assign col_oob    = cmd_col > HLast;
  assign row_oob    = cmd_row > VLast;
  assign start_addr = ADDR_W'(cmd_row) * HStride + ADDR_W'(cmd_col);

  // Command FSM with raster address generation; all outputs come from these registers.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      state_q     <= StIdle;
      wr_addr_q   <= '0;
      row_start_q <= '0;
      color_q     <= '0;
      col_q       <= '0;
      col_start_q <= '0;
      end_col_q   <= '0;
      row_q       <= '0;
      end_row_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle, StFin: begin
          state_q <= StIdle;
          if (accept) begin
            color_q     <= cmd_color;
            wr_addr_q   <= start_addr;
            row_start_q <= start_addr;
            col_q       <= cmd_col;
            col_start_q <= cmd_col;
            row_q       <= cmd_row;
            end_col_q   <= end_col_c;
            end_row_q   <= end_row_c;
            unique case (cmd_op)
              2'b00: begin
                if (row_oob || col_oob) begin
                  state_q <= StFin;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                end else begin
                  state_q <= StPix;
                end
              end
              2'b01: begin
                if (cmd_w == '0 || cmd_h == '0 || row_oob || col_oob) begin
                  state_q <= StFin;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                end else begin
                  state_q <= StRect;
                end
              end
              2'b10: begin
                // Clear is a full-screen rectangle from the origin.
                state_q     <= StClr;
                wr_addr_q   <= '0;
                row_start_q <= '0;
                col_q       <= '0;
                col_start_q <= '0;
                row_q       <= '0;
                end_col_q   <= HLast;
                end_row_q   <= VLast;
              end
              default: begin
                state_q <= StFin;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end
            endcase
          end
        end
        StPix: begin
          if (fire) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end
        end
        StRect, StClr: begin
          if (fire) begin
            if (col_q == end_col_q) begin
              if (row_q == end_row_q) begin
                state_q <= StFin;
                done_q  <= 1'b1;
              end else begin
                // Next row starts one stride below the previous row start.
                row_q       <= row_q + 9'd1;
                col_q       <= col_start_q;
                row_start_q <= row_start_q + HStride;
                wr_addr_q   <= row_start_q + HStride;
              end
            end else begin
              col_q     <= col_q + 10'd1;
              wr_addr_q <= wr_addr_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_draw_writer.sv
// Randomized self-checking bench for fb_draw_writer against a raster reference model.
module tb_fb_draw_writer;

  localparam int HR = 640;
  localparam int VR = 480;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblank = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [8:0]  cmd_row = '0;
  logic [9:0]  cmd_col = '0;
  logic [8:0]  cmd_h = '0;
  logic [9:0]  cmd_w = '0;
  logic [7:0]  cmd_color = '0;
  logic        busy, wr_en, done, err;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fb_draw_writer dut (
    .iVGA_CLK  (clk),
    .iRST_n    (rst_n),
`ifdef FB_VBLANK_GATE_EN
    .vblank    (vblank),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .cmd_h     (cmd_h),
    .cmd_w     (cmd_w),
    .cmd_color (cmd_color),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: number of writes, error flag, and the raster rectangle they cover.
  task automatic model_cmd(input logic [1:0] op, input int row, input int col, input int h,
                           input int w, output int n, output bit e, output int r0,
                           output int c0, output int ew);
    int ec, er;
    n = 0; e = 1'b0; r0 = row; c0 = col; ew = 1;
    case (op)
      2'd0: if (row >= VR || col >= HR) e = 1'b1; else n = 1;
      2'd1: begin
        if (w == 0 || h == 0 || row >= VR || col >= HR) begin
          e = 1'b1;
        end else begin
          ec = (col + w - 1 < HR) ? col + w - 1 : HR - 1;
          er = (row + h - 1 < VR) ? row + h - 1 : VR - 1;
          ew = ec - col + 1;
          n  = ew * (er - row + 1);
        end
      end
      2'd2: begin r0 = 0; c0 = 0; ew = HR; n = HR * VR; end
      default: e = 1'b1;
    endcase
  endtask

  task automatic drive_gate();
`ifdef FB_VBLANK_GATE_EN
    vblank = ($urandom_range(0, 3) != 0);
`endif
  endtask

  // Issue one command from a negedge and follow it to its done pulse.
  task automatic run_cmd(input logic [1:0] op, input int row, input int col, input int h,
                         input int w, input logic [7:0] color, input string tag,
                         input bit noise);
    int n_exp, r0, c0, ew, budget, k, exp_addr;
    bit e_exp;
    int n_wr = 0, bad = 0, first_t = 0, last_t = 0, done_t = 0, busy_bad = 0, stray = 0;
    logic got_err = 1'b0, got_ready = 1'b0;
    model_cmd(op, row, col, h, w, n_exp, e_exp, r0, c0, ew);
`ifdef FB_VBLANK_GATE_EN
    budget = 2 * n_exp + 40;
`else
    budget = n_exp + 4;
`endif
    for (int g = 0; g < 20 && cmd_ready !== 1'b1; g++) @(negedge clk);
    cmd_op = op; cmd_row = 9'(row); cmd_col = 10'(col);
    cmd_h = 9'(h); cmd_w = 10'(w); cmd_color = color;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_row = 9'($urandom); cmd_col = 10'($urandom);
    cmd_h = 9'($urandom); cmd_w = 10'($urandom); cmd_color = 8'($urandom);
    for (int t = 1; t <= budget; t++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (n_wr < n_exp) begin
          k = n_wr;
          exp_addr = (r0 + k / ew) * HR + c0 + k % ew;
          if (wr_addr !== 19'(exp_addr) || wr_data !== color) begin
            if (bad == 0)
              $display("  %s first bad write #%0d addr %0d data %0d (want %0d/%0d)",
                       tag, k, wr_addr, wr_data, exp_addr, color);
            bad++;
          end
        end
        if (n_wr == 0) first_t = t;
        last_t = t;
        n_wr++;
      end
      if (done === 1'b1) begin
        done_t = t; got_err = err; got_ready = cmd_ready;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (err === 1'b1) stray++;
      cmd_valid = noise & 1'($urandom_range(0, 1));
      cmd_op = 2'($urandom); cmd_row = 9'($urandom); cmd_col = 10'($urandom);
      drive_gate();
    end
    cmd_valid = 1'b0;
`ifdef FB_VBLANK_GATE_EN
    vblank = 1'b1;
`endif
    check({tag, "/writes"}, n_wr, n_exp);
    check({tag, "/bad_writes"}, bad, 0);
    check({tag, "/done_seen"}, 32'(done_t != 0), 1);
    check({tag, "/err"}, got_err, e_exp);
    check({tag, "/ready_at_done"}, got_ready, 1);
    check({tag, "/done_time"}, done_t, (n_exp > 0) ? last_t + 1 : 1);
    check({tag, "/busy_drop"}, busy_bad, 0);
    check({tag, "/stray_err"}, stray, 0);
`ifndef FB_VBLANK_GATE_EN
    if (n_exp > 0) check({tag, "/first_write_t"}, first_t, 1);
`endif
    @(negedge clk);
    check({tag, "/done_one_cycle"}, {wr_en, done, err}, 3'b000);
  endtask

  initial begin
    int cnt;
    logic [1:0] op;
    int row, col, h, w;

    repeat (3) @(negedge clk);
    check("rst/ready", cmd_ready, 1);
    check("rst/busy", busy, 0);
    check("rst/pulses", {wr_en, done, err}, 3'b000);
    check("rst/addr", wr_addr, 0);
    check("rst/data", wr_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(2'd0, 10, 20, 0, 0, 8'd5, "pix_10_20", 1'b0);
    run_cmd(2'd0, 480, 0, 0, 0, 8'd7, "pix_row480", 1'b0);
    run_cmd(2'd0, 479, 639, 0, 0, 8'd200, "pix_corner", 1'b1);
    run_cmd(2'd1, 478, 638, 4, 4, 8'd9, "rect_corner", 1'b0);
    run_cmd(2'd1, 5, 5, 0, 3, 8'd1, "rect_h0", 1'b0);
    run_cmd(2'd1, 5, 640, 2, 3, 8'd1, "rect_col640", 1'b0);
    run_cmd(2'd3, 1, 1, 1, 1, 8'd3, "op_rsvd", 1'b0);
    run_cmd(2'd2, 0, 0, 0, 0, 8'd0, "clear", 1'b1);

    // Reset while a rectangle is in progress.
    cmd_op = 2'd1; cmd_row = 9'd100; cmd_col = 10'd100; cmd_h = 9'd5; cmd_w = 10'd20;
    cmd_color = 8'd44; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cnt = 0;
    for (int g = 0; g < 100 && cnt < 3; g++) begin
      @(negedge clk);
      if (wr_en === 1'b1) cnt++;
    end
    check("rst_mid/three_writes", cnt, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid/wr_en", wr_en, 0);
    check("rst_mid/ready", cmd_ready, 1);
    check("rst_mid/done", done, 0);
    check("rst_mid/addr", wr_addr, 0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || done !== 1'b0) cnt++;
    end
    check("rst_mid/quiet_after", cnt, 0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = 2'd0;
        8:       op = 2'd3;
        default: op = 2'd1;
      endcase
      row = ($urandom_range(0, 3) == 0) ? $urandom_range(470, 511) : $urandom_range(0, 479);
      col = ($urandom_range(0, 3) == 0) ? $urandom_range(630, 1023) : $urandom_range(0, 639);
      h   = $urandom_range(0, 8);
      w   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 12);
      run_cmd(op, row, col, h, w, 8'($urandom), $sformatf("rnd%0d", i), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
